svc_mem_sram_arb: RTL

Two-master arbiter in front of a single `svc_mem_sram` instance (zero-latency read port, byte-strobed write port). It gives master 0 (instruction fetch) and master 1 (load/store) independent round-robin access to the SRAM read and write ports. It registers each read response back to the master that issued it. It blocks a read that targets the word being written in the same cycle, so every read observes all previously accepted writes.

---
 rtl/svc_mem_sram_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/svc_mem_sram_arb.sv
`default_nettype none
// ============================================================================
// Module  : svc_mem_sram_arb
// Purpose : Two-master arbiter in front of one zero-latency SRAM.
//           Master 0 (instruction fetch) and master 1 (load/store) get
//           independent round-robin access to the SRAM read and write ports.
//           Read responses are registered back to the issuing master one
//           cycle after acceptance. A read that targets the word being
//           written in the same cycle is held off for a cycle, so every read
//           observes all previously accepted writes.
// Ports   :
//   clk, rst                       clock, synchronous active-high reset
//   mX_rd_valid/addr               read request (byte address, [1:0] ignored)
//   mX_rd_ready                    read accepted this cycle
//   mX_rd_data/mX_rd_data_valid    registered response, one-cycle pulse
//   mX_wr_valid/addr/data/strb     write request with byte enables
//   mX_wr_ready                    write accepted this cycle
//   sram_rd_*                      SRAM read port (data returns same cycle)
//   sram_wr_*                      SRAM write port (written at clock edge)
// Revision: 1.0 - initial release
// ============================================================================
module svc_mem_sram_arb #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_rd_valid,
  input  logic [31:0]     m0_rd_addr,
  output logic            m0_rd_ready,
  output logic [DW-1:0]   m0_rd_data,
  output logic            m0_rd_data_valid,

  input  logic            m1_rd_valid,
  input  logic [31:0]     m1_rd_addr,
  output logic            m1_rd_ready,
  output logic [DW-1:0]   m1_rd_data,
  output logic            m1_rd_data_valid,

  input  logic            m0_wr_valid,
  input  logic [31:0]     m0_wr_addr,
  input  logic [DW-1:0]   m0_wr_data,
  input  logic [DW/8-1:0] m0_wr_strb,
  output logic            m0_wr_ready,

  input  logic            m1_wr_valid,
  input  logic [31:0]     m1_wr_addr,
  input  logic [DW-1:0]   m1_wr_data,
  input  logic [DW/8-1:0] m1_wr_strb,
  output logic            m1_wr_ready,

  output logic [31:0]     sram_rd_addr,
  output logic            sram_rd_valid,
  input  logic [DW-1:0]   sram_rd_data,
  input  logic            sram_rd_data_valid,

  output logic [31:0]     sram_wr_addr,
  output logic [DW-1:0]   sram_wr_data,
  output logic [DW/8-1:0] sram_wr_strb,
  output logic            sram_wr_valid
);

  // Last-granted master per channel (0 = m0, 1 = m1).
  logic          last_wr_q, last_wr_d;
  logic          last_rd_q, last_rd_d;

  // One-hot response owner: bit0 = m0, bit1 = m1, 2'b00 = no response.
  logic [1:0]    rsp_own_q, rsp_own_d;

  logic [DW-1:0] m0_data_q, m0_data_d;
  logic [DW-1:0] m1_data_q, m1_data_d;

  logic          wr_gnt0, wr_gnt1;
  logic          rd_cand0, rd_cand1;
  logic [31:0]   rd_cand_addr;
  logic          rd_hazard;
  logic          rd_iss0, rd_iss1;

  // --------------------------------------------------------------------------
  // Write channel: round-robin grant and request mux.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_gnt0       = m0_wr_valid && (!m1_wr_valid || last_wr_q);
    wr_gnt1       = m1_wr_valid && (!m0_wr_valid || !last_wr_q);

    sram_wr_addr  = m0_wr_addr;
    sram_wr_data  = m0_wr_data;
    sram_wr_strb  = m0_wr_strb;
    if (wr_gnt1) begin
      sram_wr_addr = m1_wr_addr;
      sram_wr_data = m1_wr_data;
      sram_wr_strb = m1_wr_strb;
    end
    sram_wr_valid = wr_gnt0 || wr_gnt1;

    m0_wr_ready   = wr_gnt0;
    m1_wr_ready   = wr_gnt1;

    last_wr_d     = last_wr_q;
    if (sram_wr_valid) begin
      last_wr_d = wr_gnt1;
    end
  end

  // --------------------------------------------------------------------------
  // Read channel: pick a round-robin candidate, then block it if it hits the
  // word being written this cycle. A blocked candidate is not replaced by the
  // other master and the round-robin pointer stays put, so the same master
  // wins again next cycle once the write has landed.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_cand0      = m0_rd_valid && (!m1_rd_valid || last_rd_q);
    rd_cand1      = m1_rd_valid && (!m0_rd_valid || !last_rd_q);
    rd_cand_addr  = rd_cand1 ? m1_rd_addr : m0_rd_addr;

    rd_hazard     = sram_wr_valid &&
                    (rd_cand_addr[AW+1:2] == sram_wr_addr[AW+1:2]);

    rd_iss0       = rd_cand0 && !rd_hazard;
    rd_iss1       = rd_cand1 && !rd_hazard;

    sram_rd_addr  = rd_cand_addr;
    sram_rd_valid = rd_iss0 || rd_iss1;

    m0_rd_ready   = rd_iss0;
    m1_rd_ready   = rd_iss1;

    last_rd_d     = last_rd_q;
    if (sram_rd_valid) begin
      last_rd_d = rd_iss1;
    end
  end

  // --------------------------------------------------------------------------
  // Response capture. Data is captured on every accepted read; the pulse is
  // suppressed when the SRAM flags the read as invalid.
  // --------------------------------------------------------------------------
  always_comb begin
    m0_data_d = m0_data_q;
    m1_data_d = m1_data_q;
    if (rd_iss0) begin
      m0_data_d = sram_rd_data;
    end
    if (rd_iss1) begin
      m1_data_d = sram_rd_data;
    end
    rsp_own_d = {rd_iss1 && sram_rd_data_valid, rd_iss0 && sram_rd_data_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_q <= 1'b1;
      last_rd_q <= 1'b1;
      rsp_own_q <= 2'b00;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      last_wr_q <= last_wr_d;
      last_rd_q <= last_rd_d;
      rsp_own_q <= rsp_own_d;
      m0_data_q <= m0_data_d;
      m1_data_q <= m1_data_d;
    end
  end

  assign m0_rd_data       = m0_data_q;
  assign m1_rd_data       = m1_data_q;
  assign m0_rd_data_valid = rsp_own_q[0];
  assign m1_rd_data_valid = rsp_own_q[1];

endmodule
`default_nettype wire
